pool_scan_engine: RTL

POOL_SCAN_ENGINE -- requirements
Module: pool_scan_engine

---
 rtl/snn_interfaces_pkg.sv | 30 +++
 rtl/pool_neuron_update.sv | 22 ++
 rtl/pool_scan_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/snn_interfaces_pkg.sv
// Shared SNN interface types: pixel coordinate, spike event, scan FSM encoding and default sizing.
package snn_interfaces_pkg;

  localparam int unsigned DEFAULT_COORD_BITS  = 8;
  localparam int unsigned DEFAULT_CHANNELS    = 4;
  localparam int unsigned DEFAULT_NEURON_BITS = 8;
  localparam int unsigned DEFAULT_IMG_WIDTH   = 4;
  localparam int unsigned DEFAULT_IMG_HEIGHT  = 4;
  localparam int unsigned DEFAULT_THRESHOLD   = 100;
  localparam int unsigned DEFAULT_LEAK        = 5;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  typedef struct packed {
    vec2_t                       coord;
    logic [DEFAULT_CHANNELS-1:0] mask;
  } spike_event_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } scan_state_e;

endpackage

// File: rtl/pool_neuron_update.sv
// One channel of the pool update: saturating leak, threshold compare, reset-on-spike.
module pool_neuron_update #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned THRESHOLD = 100,
  parameter int unsigned LEAK      = 5
) (
  input  logic [BITS-1:0] v_i,
  output logic [BITS-1:0] wr_o,
  output logic            spike_o
);

  logic [BITS-1:0] leaked_c;

  // Leak saturates at zero instead of wrapping.
  always_comb begin
    leaked_c = '0;
    if (32'(v_i) >= LEAK) leaked_c = v_i - BITS'(LEAK);
    spike_o = (32'(leaked_c) >= THRESHOLD);
    wr_o    = spike_o ? '0 : leaked_c;
  end

endmodule

// File: rtl/pool_scan_engine.sv
// Row-major read/leak/write scan over the membrane pool, emitting per-pixel spike events.
module pool_scan_engine
  import snn_interfaces_pkg::*;
#(
  parameter int unsigned COORD_BITS       = DEFAULT_COORD_BITS,
  parameter int unsigned CHANNELS         = DEFAULT_CHANNELS,
  parameter int unsigned BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
  parameter int unsigned IMG_WIDTH        = DEFAULT_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT       = DEFAULT_IMG_HEIGHT,
  parameter int unsigned THRESHOLD        = DEFAULT_THRESHOLD,
  parameter int unsigned LEAK             = DEFAULT_LEAK
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         read_req,
  output vec2_t                                        coord_get,
  input  logic                                         read_ready,
  input  logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0]    data_out,
  output logic                                         write_req,
  output vec2_t                                        coord_wtr,
  output logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0]    data_in,
  input  logic                                         write_ready,
  output logic                                         spike_valid,
  input  logic                                         spike_ready,
  output vec2_t                                        spike_coord,
  output logic [CHANNELS-1:0]                          spike_mask
);

  localparam int unsigned CW = COORD_BITS;
  localparam int unsigned VW = DEFAULT_COORD_BITS;

  scan_state_e state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] data_q, wr_val_c;
  logic [CHANNELS-1:0] mask_q, spike_c;
  logic cap_en_c, wr_exit_c, last_px_c;

  for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : g_neuron
    pool_neuron_update #(
      .BITS      (BITS_PER_CHANNEL),
      .THRESHOLD (THRESHOLD),
      .LEAK      (LEAK)
    ) u_neuron (
      .v_i     (data_out[ch]),
      .wr_o    (wr_val_c[ch]),
      .spike_o (spike_c[ch])
    );
  end

  // A spiking pixel may only retire once its event is taken, so write and spike leave together.
  assign wr_exit_c = write_ready && ((mask_q == '0) || spike_ready);
  assign last_px_c = (x_q == CW'(IMG_WIDTH - 1)) && (y_q == CW'(IMG_HEIGHT - 1));

  assign coord_get   = '{x: VW'(x_q), y: VW'(y_q)};
  assign coord_wtr   = '{x: VW'(x_q), y: VW'(y_q)};
  assign spike_coord = '{x: VW'(x_q), y: VW'(y_q)};
  assign data_in     = data_q;
  assign spike_mask  = mask_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cap_en_c    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    read_req    = 1'b0;
    write_req   = 1'b0;
    spike_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = RD;
        end
      end
      RD: begin
        busy     = 1'b1;
        read_req = read_ready;
        if (read_ready) state_d = CAP;
      end
      CAP: begin
        busy     = 1'b1;
        cap_en_c = 1'b1;
        state_d  = WR;
      end
      WR: begin
        busy        = 1'b1;
        spike_valid = (mask_q != '0);
        if (wr_exit_c) begin
          write_req = 1'b1;
          if (last_px_c) begin
            state_d = DONE;
          end else begin
            state_d = RD;
            if (x_q == CW'(IMG_WIDTH - 1)) begin
              x_d = '0;
              y_d = y_q + CW'(1);
            end else begin
              x_d = x_q + CW'(1);
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Post-update values are captured once in CAP so WR outputs stay frozen through any stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (cap_en_c) begin
        data_q <= wr_val_c;
        mask_q <= spike_c;
      end
    end
  end

endmodule
